// File: rtl/knight_rider_mode_ctrl.sv
// Configuration controller for the knight-rider scanner: debounces the rate,
// brightness and auto-demo buttons and holds the rate/brightness selections.
module knight_rider_mode_ctrl #(
  parameter int CLK_FREQ        = 6000,
  parameter int DEBOUNCE_CYCLES = CLK_FREQ / 200,
  parameter int AUTO_PERIOD     = CLK_FREQ * 2,
  parameter int RATE_W          = 2,
  parameter int BRIGHT_W        = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btn_rate,
  input  logic                btn_bright,
  input  logic                btn_auto,
  output logic [RATE_W-1:0]   rate_sel,
  output logic [BRIGHT_W-1:0] bright_sel,
  output logic                auto_active,
  output logic                cfg_update
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int ACNT_W = $clog2(AUTO_PERIOD);
  localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ACNT_W-1:0] AUTO_LAST = ACNT_W'(AUTO_PERIOD - 1);

  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } mode_t;

  // Bit order: 0 = rate, 1 = brightness, 2 = auto-demo toggle
  logic [2:0] btn_raw;
  logic [2:0] press;

  assign btn_raw = {btn_auto, btn_bright, btn_rate};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
      logic             sync1_reg;
      logic             sync2_reg;
      logic             db_reg;
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          db_reg    <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= btn_raw[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg == db_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DB_LAST) begin
            db_reg  <= sync2_reg;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      // Only the rising debounced transition is an event; release is silent
      assign press[gi] = (sync2_reg != db_reg) && (cnt_reg == DB_LAST) && sync2_reg;
    end
  endgenerate

  mode_t               mode_reg, mode_next;
  logic [RATE_W-1:0]   rate_reg, rate_next;
  logic [BRIGHT_W-1:0] bright_reg, bright_next;
  logic [ACNT_W-1:0]   auto_cnt_reg, auto_cnt_next;
  logic                cfg_update_reg, cfg_update_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_reg       <= MANUAL;
      rate_reg       <= '0;
      bright_reg     <= '1;
      auto_cnt_reg   <= '0;
      cfg_update_reg <= 1'b0;
    end else begin
      mode_reg       <= mode_next;
      rate_reg       <= rate_next;
      bright_reg     <= bright_next;
      auto_cnt_reg   <= auto_cnt_next;
      cfg_update_reg <= cfg_update_next;
    end
  end

  always_comb begin
    mode_next     = mode_reg;
    rate_next     = rate_reg;
    bright_next   = bright_reg;
    auto_cnt_next = auto_cnt_reg;

    // A manual press always wins: it cancels auto mode and any auto step
    if (press[0] || press[1]) begin
      mode_next = MANUAL;
      if (press[0]) rate_next = rate_reg + 1'b1;
      if (press[1]) bright_next = bright_reg + 1'b1;
    end else begin
      case (mode_reg)
        MANUAL: begin
          if (press[2]) begin
            mode_next     = AUTO;
            auto_cnt_next = '0;
          end
        end
        AUTO: begin
          if (press[2]) begin
            mode_next = MANUAL;
          end else if (auto_cnt_reg == AUTO_LAST) begin
            auto_cnt_next = '0;
            rate_next     = rate_reg + 1'b1;
            if (rate_reg == '1) bright_next = bright_reg + 1'b1;
          end else begin
            auto_cnt_next = auto_cnt_reg + 1'b1;
          end
        end
        default: mode_next = MANUAL;
      endcase
    end

    cfg_update_next = (rate_next != rate_reg) || (bright_next != bright_reg);
  end

  assign rate_sel    = rate_reg;
  assign bright_sel  = bright_reg;
  assign auto_active = (mode_reg == AUTO);
  assign cfg_update  = cfg_update_reg;

endmodule

// File: tb/tb_knight_rider_mode_ctrl.sv
// Directed bench for knight_rider_mode_ctrl with short debounce/auto periods
// so every press, wrap and auto-demo step is reachable in a few hundred cycles.
module tb_knight_rider_mode_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_rate;
  logic       btn_bright;
  logic       btn_auto;
  logic [1:0] rate_sel;
  logic [2:0] bright_sel;
  logic       auto_active;
  logic       cfg_update;

  int vectors     = 0;
  int miscompares = 0;

  // Hand-derived press results for four rate presses from reset
  int rate_prev[4] = '{0, 1, 2, 3};
  int rate_seq[4]  = '{1, 2, 3, 0};

  knight_rider_mode_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .AUTO_PERIOD    (5),
    .RATE_W         (2),
    .BRIGHT_W       (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_rate   (btn_rate),
    .btn_bright (btn_bright),
    .btn_auto   (btn_auto),
    .rate_sel   (rate_sel),
    .bright_sel (bright_sel),
    .auto_active(auto_active),
    .cfg_update (cfg_update)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int er, input int eb, input int ea, input int ec);
    chk({tag, "/rate_sel"},    32'(rate_sel),    32'(er));
    chk({tag, "/bright_sel"},  32'(bright_sel),  32'(eb));
    chk({tag, "/auto_active"}, 32'(auto_active), 32'(ea));
    chk({tag, "/cfg_update"},  32'(cfg_update),  32'(ec));
  endtask

  // Auto-demo from rate 0 / bright 7: bright wraps to 0 on the 4th step, then +1 per 4 steps
  function automatic int auto_bright(input int n);
    return (n < 4) ? 7 : (n / 4 - 1);
  endfunction

  initial begin
    reset      = 1'b1;
    btn_rate   = 1'b0;
    btn_bright = 1'b0;
    btn_auto   = 1'b0;
    step(2);
    chk_state("reset", 0, 7, 0, 0);

    // Held rate button: one step at edge 6, nothing more while held or released
    reset    = 1'b0;
    btn_rate = 1'b1;
    step(5);
    chk_state("t1_pre", 0, 7, 0, 0);
    step(1);
    chk_state("t1_press", 1, 7, 0, 1);
    step(1);
    chk_state("t1_strobe_end", 1, 7, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk_state("t1_hold", 1, 7, 0, 0);
    end
    btn_rate = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk_state("t1_release", 1, 7, 0, 0);
    end

    // Bright glitch of 3 synchronized cycles is rejected
    btn_bright = 1'b1;
    step(3);
    btn_bright = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk_state("t2_glitch", 1, 7, 0, 0);
    end

    // Exactly 4 synchronized cycles is accepted; brightness wraps 7 -> 0
    btn_bright = 1'b1;
    step(4);
    btn_bright = 1'b0;
    step(1);
    chk_state("t2b_pre", 1, 7, 0, 0);
    step(1);
    chk_state("t2b_press", 1, 0, 0, 1);
    step(10);
    chk_state("t2b_settled", 1, 0, 0, 0);

    // Four rate presses from reset: 1, 2, 3, 0
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      btn_rate = 1'b1;
      step(5);
      chk_state("t3_pre", rate_prev[k], 7, 0, 0);
      step(1);
      chk_state("t3_press", rate_seq[k], 7, 0, 1);
      step(1);
      chk_state("t3_after", rate_seq[k], 7, 0, 0);
      btn_rate = 1'b0;
      step(8);
    end

    // Auto-demo: enter, then 20 terminal counts every 5 cycles
    reset = 1'b1;
    step(1);
    reset    = 1'b0;
    btn_auto = 1'b1;
    step(5);
    chk_state("t4_pre", 0, 7, 0, 0);
    step(1);
    chk_state("t4_enter", 0, 7, 1, 0);
    btn_auto = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      step(4);
      chk_state("t4_hold", (n - 1) % 4, auto_bright(n - 1), 1, 0);
      step(1);
      chk_state("t4_step", n % 4, auto_bright(n), 1, 1);
    end

    // Rate press landing on a terminal count: one step only, back to MANUAL
    step(4);
    btn_rate = 1'b1;
    step(1);
    chk_state("t5_auto_step", 1, 4, 1, 1);
    step(4);
    chk_state("t5_pre", 1, 4, 1, 0);
    step(1);
    chk_state("t5_coincide", 2, 4, 0, 1);
    btn_rate = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk_state("t5_frozen", 2, 4, 0, 0);
    end

    // Reset during AUTO with the bright button mid-debounce (cnt = 2)
    btn_auto = 1'b1;
    step(6);
    chk_state("t6_enter", 2, 4, 1, 0);
    btn_auto = 1'b0;
    step(8);
    btn_bright = 1'b1;
    step(4);
    reset = 1'b1;
    step(1);
    chk_state("t6_reset", 0, 7, 0, 0);
    reset = 1'b0;
    step(5);
    chk_state("t6_pre", 0, 7, 0, 0);
    step(1);
    chk_state("t6_press", 0, 0, 0, 1);
    for (int i = 0; i < 7; i++) begin
      step(1);
      chk_state("t6_hold", 0, 0, 0, 0);
    end
    btn_bright = 1'b0;
    step(8);

    // Rate and bright pressed together: both step
    btn_rate   = 1'b1;
    btn_bright = 1'b1;
    step(6);
    chk_state("t7_both", 1, 1, 0, 1);
    btn_rate   = 1'b0;
    btn_bright = 1'b0;
    step(8);

    // Rate and auto pressed together in MANUAL: rate steps, stays MANUAL
    btn_rate = 1'b1;
    btn_auto = 1'b1;
    step(6);
    chk_state("t8_rate_auto", 2, 1, 0, 1);
    btn_rate = 1'b0;
    btn_auto = 1'b0;
    step(8);
    chk_state("t8_settled", 2, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
